// File: rtl/shift_pkg.sv
// Shared definitions for the shift unit.
//   shift_op_t : 3-bit operation code. Encodings 5..7 are illegal and give a
//                zero result with the error flag set.
//   WIDTH      : data width. Only 32 is supported.
//   AMT_W      : shift-amount width, log2(WIDTH).
package shift_pkg;

  localparam int WIDTH = 32;
  localparam int AMT_W = 5;

  typedef enum logic [2:0] {
    OP_SLL = 3'd0,
    OP_SRL = 3'd1,
    OP_SRA = 3'd2,
    OP_ROL = 3'd3,
    OP_ROR = 3'd4
  } shift_op_t;

endpackage

// File: rtl/cyclic_barrel_shifter.sv
// Combinational left-cyclic rotator built as a logarithmic barrel shifter.
//   data_i : operand
//   amt_i  : left-rotate amount, 0..W-1
//   data_o : data_i rotated left by amt_i
module cyclic_barrel_shifter #(
  parameter int W  = 32,
  parameter int AW = 5
) (
  input  logic [W-1:0]  data_i,
  input  logic [AW-1:0] amt_i,
  output logic [W-1:0]  data_o
);

  logic [W-1:0] stage;

  // Stage k rotates by 2**k when bit k of the amount is set.
  always_comb begin
    stage = data_i;
    for (int k = 0; k < AW; k++) begin
      if (amt_i[k]) begin
        stage = (stage << (1 << k)) | (stage >> (W - (1 << k)));
      end
    end
    data_o = stage;
  end

endmodule

// File: rtl/shift_unit.sv
// Two-stage pipelined shift/rotate unit.
//   clk, rst               : clock, synchronous active-high reset
//   in_valid/in_ready      : request handshake
//   in_op/in_data/in_amt   : operation, operand, amount
//   out_valid/out_ready    : result handshake
//   out_data/out_zero/out_err : result, result-is-zero, illegal-op flag
//
// Handshake: a transfer happens at a rising edge where valid && ready. A
// producer holding valid=1 keeps its payload stable until the transfer; the
// unit holds out_* stable while out_valid=1 and out_ready=0. in_ready depends
// combinationally on out_ready so a full pipeline drains and refills in the
// same cycle, giving one result per cycle with no bubbles.
//
// S1 registers the request; the rotate, masking and sign fill happen between
// S1 and S2; S2 registers the result with its zero and error flags.
module shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_err
);

  logic             s1_valid_q;
  shift_op_t        s1_op_q;
  logic [WIDTH-1:0] s1_data_q;
  logic [AMT_W-1:0] s1_amt_q;

  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_data_q;
  logic             s2_zero_q;
  logic             s2_err_q;

  logic             s1_adv;
  logic             s2_adv;

  logic [AMT_W-1:0] rot_amt;
  logic [WIDTH-1:0] rot;
  logic [WIDTH-1:0] mask_l;
  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] res_d;
  logic             zero_d;
  logic             err_d;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv && !rst;

  // Right shifts and ROR are left rotates by (WIDTH - amt) mod WIDTH, i.e. the
  // two's-complement negation of amt in AMT_W bits.
  always_comb begin
    case (s1_op_q)
      OP_SLL, OP_ROL: rot_amt = s1_amt_q;
      default:        rot_amt = ~s1_amt_q + AMT_W'(1);
    endcase
  end

  cyclic_barrel_shifter #(
    .W  (WIDTH),
    .AW (AMT_W)
  ) u_rot (
    .data_i (s1_data_q),
    .amt_i  (rot_amt),
    .data_o (rot)
  );

  assign mask_l = {WIDTH{1'b1}} << s1_amt_q;
  assign mask_r = {WIDTH{1'b1}} >> s1_amt_q;

  always_comb begin
    res_d = '0;
    err_d = 1'b0;
    case (s1_op_q)
      OP_SLL:         res_d = rot & mask_l;
      OP_SRL:         res_d = rot & mask_r;
      // Bits cleared by the right mask are the top amt bits; fill them with
      // the sign bit.
      OP_SRA:         res_d = (rot & mask_r) | (s1_data_q[WIDTH-1] ? ~mask_r : '0);
      OP_ROL, OP_ROR: res_d = rot;
      default:        err_d = 1'b1;
    endcase
    zero_d = (res_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_zero_q  <= 1'b1;
      s2_err_q   <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_op_q   <= shift_op_t'(in_op);
          s1_data_q <= in_data;
          s1_amt_q  <= in_amt;
        end
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= res_d;
          s2_zero_q <= zero_d;
          s2_err_q  <= err_d;
        end
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_zero  = s2_zero_q;
  assign out_err   = s2_err_q;

endmodule

// File: tb/tb_shift_unit.sv
// Bench for shift_unit: directed vectors with literal expectations, random
// streams checked against a behavioural model, backpressure and reset cases.
module tb_shift_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_data;
  logic [4:0]  in_amt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_zero;
  logic        out_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_out = 0;
  int first_out_cyc = 0;
  int last_out_cyc = 0;

  logic [33:0] exp_q[$];
  logic        held_v = 1'b0;
  logic [33:0] held;

  always #5 clk = ~clk;

  shift_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .out_err   (out_err)
  );

  // Behavioural reference: {err, zero, data}.
  function automatic logic [33:0] model(logic [2:0] op, logic [31:0] d, logic [4:0] a);
    logic [31:0]        r;
    logic signed [31:0] sd;
    int                 sa;
    sd = d;
    sa = 32 - int'(a);
    r  = '0;
    case (op)
      3'd0: r = d << a;
      3'd1: r = d >> a;
      3'd2: r = sd >>> a;
      3'd3: r = (a == 0) ? d : ((d << a) | (d >> sa));
      3'd4: r = (a == 0) ? d : ((d >> a) | (d << sa));
      default: return {1'b1, 1'b1, 32'h0};
    endcase
    return {1'b0, (r == 32'h0), r};
  endfunction

  task automatic chk_b(string nm, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic chk_w(string nm, logic [33:0] act, logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%09h expected 0x%09h", nm, act, exp);
    end
  endtask

  task automatic chk_i(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard and output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        chk_b("stall_valid_held", out_valid, 1'b1);
        chk_w("stall_data_held", {out_err, out_zero, out_data}, held);
      end
      held_v = out_valid && !out_ready;
      held   = {out_err, out_zero, out_data};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got 0x%08h expected no result", out_data);
        end else begin
          chk_w("result", {out_err, out_zero, out_data}, exp_q.pop_front());
        end
        if (n_out == 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
        n_out++;
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_op, in_data, in_amt));
    end
  end

  // Single request into an idle pipeline: raised after edge K, accepted at
  // edge K+1, result visible after edge K+2.
  task automatic single(string nm, logic [2:0] op, logic [31:0] d, logic [4:0] a,
                        logic [31:0] ed, logic ez, logic ee);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = op;
    in_data   = d;
    in_amt    = a;
    @(negedge clk);
    chk_b({nm, "_in_ready"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk_b({nm, "_early"}, out_valid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk_b({nm, "_valid"}, out_valid, 1'b1);
    chk_w({nm, "_out"}, {out_err, out_zero, out_data}, {ee, ez, ed});
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int budget = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && budget < 30) begin
      @(posedge clk); #1;
      budget++;
    end
    chk_i("drain", exp_q.size(), 0);
  endtask

  // Random stream of n requests; out_ready is low for stall_len cycles from
  // stream cycle stall_at.
  task automatic stream(int n, int max_op, int stall_at, int stall_len,
                        output int acc_in_stall, output int cycles);
    int   sent = 0;
    int   c = 0;
    logic acc;
    logic need_new = 1'b1;
    acc_in_stall = 0;
    while (sent < n && c < 200) begin
      out_ready = !(c >= stall_at && c < stall_at + stall_len);
      if (need_new) begin
        in_op    = 3'($urandom_range(0, max_op));
        in_data  = $urandom;
        in_amt   = 5'($urandom_range(0, 31));
        need_new = 1'b0;
      end
      in_valid = 1'b1;
      @(negedge clk);
      acc = in_ready;
      if (!out_ready && acc) acc_in_stall++;
      if (stall_len > 0 && c == stall_at + stall_len - 1)
        chk_b("stall_in_ready_low", in_ready, 1'b0);
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        need_new = 1'b1;
      end
      c++;
    end
    in_valid = 1'b0;
    cycles = c;
    chk_i("stream_sent", sent, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int cycles;
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_data = '0; in_amt = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_b("rst_in_ready", in_ready, 1'b0);
    chk_b("rst_out_valid", out_valid, 1'b0);
    chk_w("rst_out", {out_err, out_zero, out_data}, {1'b0, 1'b1, 32'h0});
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_b("post_rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Literal pins on the model itself.
    chk_w("model_sll", model(3'd0, 32'h8000_0001, 5'd4),  {2'b00, 32'h0000_0010});
    chk_w("model_sra", model(3'd2, 32'h8000_0000, 5'd31), {2'b00, 32'hFFFF_FFFF});
    chk_w("model_srl", model(3'd1, 32'h8000_0000, 5'd31), {2'b00, 32'h0000_0001});
    chk_w("model_ror", model(3'd4, 32'h0000_0001, 5'd1),  {2'b00, 32'h8000_0000});
    chk_w("model_rol", model(3'd3, 32'h8000_0001, 5'd4),  {2'b00, 32'h0000_0018});
    chk_w("model_ill", model(3'd6, 32'h1234_5678, 5'd3),  {2'b11, 32'h0});

    // Directed vectors.
    single("sll4",   3'd0, 32'h8000_0001, 5'd4,  32'h0000_0010, 1'b0, 1'b0);
    single("sra31",  3'd2, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b0);
    single("srl31",  3'd1, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, 1'b0);
    single("ror1",   3'd4, 32'h0000_0001, 5'd1,  32'h8000_0000, 1'b0, 1'b0);
    single("rol4",   3'd3, 32'h8000_0001, 5'd4,  32'h0000_0018, 1'b0, 1'b0);
    single("sra4p",  3'd2, 32'h7000_00F0, 5'd4,  32'h0700_000F, 1'b0, 1'b0);
    single("sll_z",  3'd0, 32'h8000_0000, 5'd1,  32'h0000_0000, 1'b1, 1'b0);
    // amt=0 boundary for every legal op.
    single("sll0",   3'd0, 32'hA5C3_0F96, 5'd0,  32'hA5C3_0F96, 1'b0, 1'b0);
    single("srl0",   3'd1, 32'hA5C3_0F96, 5'd0,  32'hA5C3_0F96, 1'b0, 1'b0);
    single("sra0",   3'd2, 32'hA5C3_0F96, 5'd0,  32'hA5C3_0F96, 1'b0, 1'b0);
    single("rol0",   3'd3, 32'hA5C3_0F96, 5'd0,  32'hA5C3_0F96, 1'b0, 1'b0);
    single("ror0",   3'd4, 32'hA5C3_0F96, 5'd0,  32'hA5C3_0F96, 1'b0, 1'b0);
    // Illegal encodings.
    single("op6",    3'd6, 32'hDEAD_BEEF, 5'd7,  32'h0000_0000, 1'b1, 1'b1);
    single("op7",    3'd7, 32'hFFFF_FFFF, 5'd0,  32'h0000_0000, 1'b1, 1'b1);

    // Back-to-back: 8 requests, 8 results on consecutive cycles.
    n_out = 0;
    stream(8, 4, 0, 0, acc, cycles);
    chk_i("b2b_in_cycles", cycles, 8);
    drain();
    chk_i("b2b_out_count", n_out, 8);
    chk_i("b2b_out_span", last_out_cyc - first_out_cyc, 7);

    // Backpressure: out_ready low for 5 cycles under continuous in_valid.
    n_out = 0;
    stream(10, 7, 0, 5, acc, cycles);
    chk_i("bp_accepts_in_stall", acc, 2);
    drain();
    chk_i("bp_out_count", n_out, 10);

    // Reset with two requests in flight.
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'd0; in_data = 32'h0000_0001; in_amt = 5'd1;
    @(posedge clk); #1;
    in_data = 32'h0000_0002;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk_b("mid_inflight_valid", out_valid, 1'b1);
    chk_i("mid_inflight_count", exp_q.size(), 2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk_b("mid_rst_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk_b("mid_post_out_valid", out_valid, 1'b0);
    chk_b("mid_post_in_ready", in_ready, 1'b1);
    n_out = 0;
    repeat (6) @(posedge clk);
    #1;
    chk_i("mid_no_ghosts", n_out, 0);

    // One more request after the reset still flows.
    single("post_mid", 3'd1, 32'hF000_0000, 5'd28, 32'h0000_000F, 1'b0, 1'b0);

    chk_i("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
